// File: rtl/subtractor_simd.sv
// rtl/subtractor_simd.sv - two-lane SIMD signed subtractor, 2-stage valid/ready pipeline
// Optional feature macro: SUB_SIMD_SAT_EN (clamp results to the W-bit signed range)
`timescale 1ns/1ps
module subtractor_simd #(
  parameter int N = 2,
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_0,
  input  logic [W-1:0] a_1,
  input  logic [W-1:0] b_0,
  input  logic [W-1:0] b_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_0,
  output logic [W:0]   out_1,
  output logic         sat_0,
  output logic         sat_1
);

  // Only the two-lane packing is implemented.
  if (N != 2) begin : g_bad_lanes
    $error("subtractor_simd supports N=2 only");
  end

  logic         s1_valid;
  logic         s2_valid;
  logic         s1_adv;
  logic         s2_adv;
  logic         in_fire;
  logic [W-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [W:0]   diff_0, diff_1;
  logic [W:0]   res_0, res_1;

  // Stage advance terms; in_ready never looks at in_valid.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_adv;
    in_ready = !s1_valid || s2_adv;
    in_fire  = in_valid && in_ready;
  end

  assign out_valid = s2_valid;

  // Sign-extend both operands by one bit so the lane difference cannot wrap.
  always_comb begin
    diff_0 = {a0_q[W-1], a0_q} - {b0_q[W-1], b0_q};
    diff_1 = {a1_q[W-1], a1_q} - {b1_q[W-1], b1_q};
  end

`ifdef SUB_SIMD_SAT_EN
  logic clamp_0, clamp_1;

  // Out of W-bit range exactly when the two top bits disagree; pick the bound by sign.
  always_comb begin
    clamp_0 = diff_0[W] ^ diff_0[W-1];
    clamp_1 = diff_1[W] ^ diff_1[W-1];
    res_0   = diff_0;
    res_1   = diff_1;
    if (clamp_0) res_0 = diff_0[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
    if (clamp_1) res_1 = diff_1[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
  end

  // Clamp flags travel with the S2 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_0 <= 1'b0;
      sat_1 <= 1'b0;
    end else if (s1_adv) begin
      sat_0 <= clamp_0;
      sat_1 <= clamp_1;
    end
  end
`else
  // Full W+1-bit difference passes straight through.
  always_comb begin
    res_0 = diff_0;
    res_1 = diff_1;
  end

  assign sat_0 = 1'b0;
  assign sat_1 = 1'b0;
`endif

  // S1: operand capture, only on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      a0_q     <= '0;
      a1_q     <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        a0_q     <= a_0;
        a1_q     <= a_1;
        b0_q     <= b_0;
        b1_q     <= b_1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2: result register; holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_0    <= '0;
      out_1    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_0 <= res_0;
        out_1 <= res_1;
      end
    end
  end

endmodule

// File: tb/tb_subtractor_simd.sv
// tb/tb_subtractor_simd.sv - directed and random self-checking bench for subtractor_simd
`timescale 1ns/1ps
module tb_subtractor_simd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] a_0, a_1, b_0, b_1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_0, out_1;
  logic        sat_0, sat_1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] e0;
    logic [15:0] e1;
    logic        s0;
    logic        s1;
  } exp_t;

  exp_t q[$];

  subtractor_simd #(.N(2), .W(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_0(out_0), .out_1(out_1),
    .sat_0(sat_0), .sat_1(sat_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a0, input int b0, input int a1, input int b1);
    a_0 = a0[14:0];
    b_0 = b0[14:0];
    a_1 = a1[14:0];
    b_1 = b1[14:0];
  endtask

  // Reference lane: exact difference, optionally clamped to [-16384, 16383].
  function automatic logic [16:0] model(input int a, input int b);
    int          d;
    logic        s;
    logic [31:0] dv;
    d = a - b;
    s = 1'b0;
`ifdef SUB_SIMD_SAT_EN
    if (d > 16383) begin d = 16383; s = 1'b1; end
    else if (d < -16384) begin d = -16384; s = 1'b1; end
`endif
    dv = d;
    return {s, dv[15:0]};
  endfunction

  function automatic logic [15:0] v16(input int v);
    logic [31:0] t;
    t = v;
    return t[15:0];
  endfunction

  task automatic chk_out(input string tag, input int a0, input int b0, input int a1, input int b1);
    logic [16:0] m0, m1;
    m0 = model(a0, b0);
    m1 = model(a1, b1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out0"}, 32'(out_0), 32'(m0[15:0]));
    chk({tag, "_out1"}, 32'(out_1), 32'(m1[15:0]));
    chk({tag, "_sat0"}, 32'(sat_0), 32'(m0[16]));
    chk({tag, "_sat1"}, 32'(sat_1), 32'(m1[16]));
  endtask

  initial begin
    int          acc;
    int          accepted;
    int          iter;
    int          drain;
    logic [15:0] held0, held1;
    logic        held_s0, held_s1;
    logic        prev_stall;
    logic        in_fire, out_fire;
    int          ra0, rb0, ra1, rb1;
    logic [16:0] m0, m1;
    exp_t        e;
    exp_t        f;

    // Reset state
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out0", 32'(out_0), 32'd0);
    chk("rst_out1", 32'(out_1), 32'd0);
    chk("rst_sat", 32'({sat_0, sat_1}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic: 100-30=70, -5-7=-12, two edges after presentation
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_in(100, 30, -5, 7);
    tick();
    in_valid = 1'b0;
    chk("basic_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("basic_out0", 32'(out_0), 32'(v16(70)));
    chk("basic_out1", 32'(out_1), 32'(v16(-12)));
    chk_out("basic", 100, 30, -5, 7);
    tick();
    chk("basic_retired", 32'(out_valid), 32'd0);

    // Extremes, negative then positive
    in_valid = 1'b1;
    set_in(0, 0, -16384, 16383);
    tick();
    set_in(16383, -16384, 0, 0);
    tick();
    in_valid = 1'b0;
`ifdef SUB_SIMD_SAT_EN
    chk("ext_neg_out1", 32'(out_1), 32'(v16(-16384)));
    chk("ext_neg_sat1", 32'(sat_1), 32'd1);
`else
    chk("ext_neg_out1", 32'(out_1), 32'(v16(-32767)));
    chk("ext_neg_sat1", 32'(sat_1), 32'd0);
`endif
    chk_out("ext_neg", 0, 0, -16384, 16383);
    tick();
`ifdef SUB_SIMD_SAT_EN
    chk("ext_pos_out0", 32'(out_0), 32'(v16(16383)));
`else
    chk("ext_pos_out0", 32'(out_0), 32'(v16(32767)));
`endif
    chk_out("ext_pos", 16383, -16384, 0, 0);
    tick();

    // Throughput: 8 back-to-back pairs, results i-1 on consecutive cycles
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        set_in(j, 1, j, 1);
        #1;
        chk("thr_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (j >= 1) chk_out("thr", j - 1, 1, j - 1, 1);
    end
    tick();
    chk("thr_drained", 32'(out_valid), 32'd0);

    // Back-pressure: 5 stalled cycles, exactly 2 accepted, output frozen
    out_ready = 1'b0;
    in_valid = 1'b1;
    accepted = 0;
    held0 = '0;
    for (int c = 0; c < 5; c++) begin
      set_in(10 + accepted, 0, -(10 + accepted), 3);
      #1;
      if (in_ready) accepted++;
      tick();
      if (c == 1) held0 = out_0;
      if (c >= 2) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_stable", 32'(out_0), 32'(held0));
      end
    end
    chk("bp_accepted", 32'(accepted), 32'd2);
    chk_out("bp_first", 10, 0, -10, 3);
    // Release with a new pair: retire and accept in the same edge
    out_ready = 1'b1;
    set_in(12, 0, -12, 3);
    #1;
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp_second", 11, 0, -11, 3);
    tick();
    chk_out("bp_third", 12, 0, -12, 3);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_in(500, 1, 600, 2);
    tick();
    set_in(700, 3, 800, 4);
    tick();
    in_valid = 1'b0;
    chk("rst2_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_out0", 32'(out_0), 32'd0);
    chk("rst2_out1", 32'(out_1), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_after_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_in(-20, 22, 9, -9);
    tick();
    in_valid = 1'b0;
    chk("rst2_lat1", 32'(out_valid), 32'd0);
    tick();
    chk_out("rst2_new", -20, 22, 9, -9);
    tick();

    // Random: scoreboard over 10k accepted pairs with random valid/ready
    acc = 0;
    iter = 0;
    prev_stall = 1'b0;
    held0 = '0; held1 = '0; held_s0 = 1'b0; held_s1 = 1'b0;
    while (acc < 10000 && iter < 40000) begin
      iter++;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ra0 = $urandom_range(0, 32767) - 16384;
      rb0 = $urandom_range(0, 32767) - 16384;
      ra1 = $urandom_range(0, 32767) - 16384;
      rb1 = $urandom_range(0, 32767) - 16384;
      set_in(ra0, rb0, ra1, rb1);
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (prev_stall) begin
        chk("rnd_stall_valid", 32'(out_valid), 32'd1);
        chk("rnd_stall_hold", 32'({out_0, out_1, sat_0, sat_1}), 32'({held0, held1, held_s0, held_s1}));
      end
      in_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_valid) begin
        chk("rnd_nonempty", 32'(q.size() > 0), 32'd1);
        if (out_fire && q.size() > 0) begin
          e = q.pop_front();
          chk("rnd_result", 32'({out_0, out_1}), {e.e0, e.e1});
          chk("rnd_sat", 32'({sat_0, sat_1}), 32'({e.s0, e.s1}));
        end
      end
      if (in_fire) begin
        m0 = model(ra0, rb0);
        m1 = model(ra1, rb1);
        f.e0 = m0[15:0]; f.s0 = m0[16];
        f.e1 = m1[15:0]; f.s1 = m1[16];
        q.push_back(f);
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      held0 = out_0; held1 = out_1; held_s0 = sat_0; held_s1 = sat_1;
      tick();
    end
    chk("rnd_all_accepted", 32'(acc), 32'd10000);

    // Drain the scoreboard with a bounded wait
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      drain++;
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_result", 32'({out_0, out_1}), {e.e0, e.e1});
        chk("drain_sat", 32'({sat_0, sat_1}), 32'({e.s0, e.s1}));
      end
      tick();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
